pc_stack: RTL and testbench

//   Parametrised program counter for the picoMIPS fetch path: sequential increment,

---
 rtl/pc_stack.sv | 122 ++++++++++++
 tb/tb_pc_stack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter with return-address LIFO: incr, jump, relative branch, call/return.
// Latency: one cycle, every output is registered and updates on the edge that samples the op.
// Backpressure: stall freezes all state; CALL on a full stack / RET on an empty one set sticky flags.
module pc_stack #(
    parameter int Psize  = 6,
    parameter int Osize  = 4,
    parameter int Sdepth = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [2:0]                     PCop,
    input  logic                           taken,
    input  logic [Psize-1:0]               target,
    input  logic [Osize-1:0]               offset,
    output logic [Psize-1:0]               PCout,
    output logic [$clog2(Sdepth+1)-1:0]    depth,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int DW = $clog2(Sdepth + 1);

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_INCR   = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    logic [Psize-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [Psize-1:0] stack_q [Sdepth];

    logic [Psize-1:0] pc_inc;
    logic [Psize-1:0] off_ext;
    logic [Psize-1:0] top_dat;
    logic             full;
    logic             empty;
    logic             push_en;

    assign pc_inc  = pc_q + Psize'(1);
    // Size cast of a signed operand sign-extends; also legal when Osize == Psize.
    assign off_ext = Psize'($signed(offset));
    assign full    = (depth_q == DW'(Sdepth));
    assign empty   = (depth_q == '0);

    // Depth doubles as the stack pointer: the top entry lives at depth-1.
    always_comb begin
        top_dat = '0;
        for (int i = 0; i < Sdepth; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_dat = stack_q[i];
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            case (PCop)
                OP_INCR:   pc_d = pc_inc;
                OP_JUMP:   pc_d = target;
                OP_BRANCH: pc_d = taken ? (pc_q + off_ext) : pc_inc;
                OP_CALL: begin
                    pc_d = target;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        depth_d = depth_q + DW'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = top_dat;
                        depth_d = depth_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Sdepth; i++) begin
            if (reset && push_en && depth_q == DW'(i)) begin
                stack_q[i] <= pc_inc;
            end
        end
    end

    assign PCout     = pc_q;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed and randomized bench for pc_stack against a queue-based reference model.
module tb_pc_stack;

    localparam int PS = 6;
    localparam int OS = 4;
    localparam int SD = 4;
    localparam int MOD = 64;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic [2:0]    op;
    logic          taken;
    logic [PS-1:0] target;
    logic [OS-1:0] offset;
    logic [PS-1:0] pc_out;
    logic [2:0]    depth;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    pc_stack #(.Psize(PS), .Osize(OS), .Sdepth(SD)) dut (
        .clk(clk), .reset(rst_n), .stall(stall), .PCop(op), .taken(taken),
        .target(target), .offset(offset), .PCout(pc_out), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input int o, input bit tk, input int tgt, input int off);
        int so;
        if (!r) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!s) begin
            case (o)
                1: m_pc = (m_pc + 1) % MOD;
                2: m_pc = tgt;
                3: begin
                    so = (off >= 8) ? off - 16 : off;
                    m_pc = tk ? ((m_pc + so) % MOD + MOD) % MOD : (m_pc + 1) % MOD;
                end
                4: begin
                    if (m_stk.size() == SD) m_ovf = 1;
                    else m_stk.push_back((m_pc + 1) % MOD);
                    m_pc = tgt;
                end
                5: begin
                    if (m_stk.size() == 0) begin
                        m_unf = 1;
                        m_pc = (m_pc + 1) % MOD;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit s, input int o, input bit tk, input int tgt, input int off);
        rst_n  = r;
        stall  = s;
        op     = 3'(o);
        taken  = tk;
        target = PS'(tgt);
        offset = OS'(off);
        @(posedge clk);
        model(r, s, o, tk, tgt, off);
        #1;
        chk("model_pc", {26'b0, pc_out}, 32'(m_pc));
        chk("model_depth", {29'b0, depth}, 32'(m_stk.size()));
        chk("model_ovf", {31'b0, overflow}, 32'(m_ovf));
        chk("model_unf", {31'b0, underflow}, 32'(m_unf));
    endtask

    initial begin
        int r;
        int o;
        m_pc = 0;
        m_ovf = 0;
        m_unf = 0;
        rst_n = 1'b0; stall = 1'b0; op = 3'd0; taken = 1'b0; target = '0; offset = '0;

        // Reset held for two cycles while INCR is requested.
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("rst_pc", {26'b0, pc_out}, 0);
        chk("rst_depth", {29'b0, depth}, 0);
        chk("rst_flags", {30'b0, overflow, underflow}, 0);
        cyc(1, 0, 1, 0, 0, 0); chk("incr1", {26'b0, pc_out}, 1);
        cyc(1, 0, 1, 0, 0, 0); chk("incr2", {26'b0, pc_out}, 2);
        cyc(1, 0, 1, 0, 0, 0); chk("incr3", {26'b0, pc_out}, 3);

        // Wrap on increment and on a negative branch.
        cyc(1, 0, 2, 0, 63, 0); chk("jump63", {26'b0, pc_out}, 63);
        cyc(1, 0, 1, 0, 0, 0);  chk("wrap0", {26'b0, pc_out}, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 3, 1, 0, 14); chk("br_neg_wrap", {26'b0, pc_out}, 63);

        // Branch not taken, then taken.
        cyc(1, 0, 2, 0, 10, 0);
        cyc(1, 0, 3, 0, 0, 5); chk("br_nt", {26'b0, pc_out}, 11);
        cyc(1, 0, 3, 1, 0, 5); chk("br_t", {26'b0, pc_out}, 16);

        // Nested call / return.
        cyc(1, 0, 2, 0, 2, 0);
        cyc(1, 0, 4, 0, 20, 0); chk("call20", {26'b0, pc_out}, 20); chk("call20_d", {29'b0, depth}, 1);
        cyc(1, 0, 4, 0, 40, 0); chk("call40", {26'b0, pc_out}, 40); chk("call40_d", {29'b0, depth}, 2);
        cyc(1, 0, 5, 0, 0, 0);  chk("ret21", {26'b0, pc_out}, 21); chk("ret21_d", {29'b0, depth}, 1);
        cyc(1, 0, 5, 0, 0, 0);  chk("ret3", {26'b0, pc_out}, 3);   chk("ret3_d", {29'b0, depth}, 0);

        // Overflow then underflow.
        for (int i = 0; i < 5; i++) cyc(1, 0, 4, 0, 8 + i, 0);
        chk("ovf_pc", {26'b0, pc_out}, 12);
        chk("ovf_depth", {29'b0, depth}, 4);
        chk("ovf_flag", {31'b0, overflow}, 1);
        chk("ovf_no_unf", {31'b0, underflow}, 0);
        cyc(1, 0, 5, 0, 0, 0); chk("pop1", {26'b0, pc_out}, 11);
        cyc(1, 0, 5, 0, 0, 0); chk("pop2", {26'b0, pc_out}, 10);
        cyc(1, 0, 5, 0, 0, 0); chk("pop3", {26'b0, pc_out}, 9);
        cyc(1, 0, 5, 0, 0, 0); chk("pop4", {26'b0, pc_out}, 4);
        chk("pop4_unf", {31'b0, underflow}, 0);
        cyc(1, 0, 5, 0, 0, 0); chk("unf_pc", {26'b0, pc_out}, 5);
        chk("unf_flag", {31'b0, underflow}, 1);
        chk("ovf_sticky", {31'b0, overflow}, 1);

        // Stall, reset during RET, reserved codes.
        cyc(1, 0, 2, 0, 30, 0);
        cyc(1, 0, 4, 0, 33, 0);
        cyc(1, 0, 4, 0, 50, 0);
        cyc(1, 1, 4, 0, 7, 0); chk("stall_pc", {26'b0, pc_out}, 50); chk("stall_d", {29'b0, depth}, 2);
        cyc(0, 0, 5, 0, 0, 0); chk("rst_ret_pc", {26'b0, pc_out}, 0); chk("rst_ret_d", {29'b0, depth}, 0);
        chk("rst_ret_flags", {30'b0, overflow, underflow}, 0);
        cyc(1, 0, 1, 0, 0, 0); chk("post_rst", {26'b0, pc_out}, 1);
        cyc(1, 0, 6, 1, 9, 3); chk("op6", {26'b0, pc_out}, 1);
        cyc(1, 0, 7, 1, 9, 3); chk("op7", {26'b0, pc_out}, 1);
        chk("rsvd_flags", {30'b0, overflow, underflow}, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:       o = 1;
                2:          o = 2;
                3, 4, 5:    o = 3;
                6, 7, 8, 9: o = 4;
                10, 11, 12, 13: o = 5;
                14:         o = 0;
                default:    o = $urandom_range(6, 7);
            endcase
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) == 0), o,
                1'($urandom_range(0, 1)), $urandom_range(0, MOD - 1), $urandom_range(0, 15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
